// File: rtl/control_sequencer_if.sv
// Control lines between control_sequencer and the single-bus DataPath.
// master = sequencer side, slave = datapath/ALU side.
interface control_sequencer_if;
   logic        run;
   logic [31:0] IR;
   logic        finished;
   logic        PCout, IRout, RFout, RZLOout, RZHIout, MDRout;
   logic        PCin, IRin, RYin, RZin, MARin, MDRin, RFin, RHIin, RLOin;
   logic        IncPC, Read, start;
   logic [4:0]  RFSelect;
   logic [5:0]  opSelect;
   logic        instr_done, illegal, fault;

   modport master (
      input  run, IR, finished,
      output PCout, IRout, RFout, RZLOout, RZHIout, MDRout,
             PCin, IRin, RYin, RZin, MARin, MDRin, RFin, RHIin, RLOin,
             IncPC, Read, start, RFSelect, opSelect, instr_done, illegal, fault
   );

   modport slave (
      output run, IR, finished,
      input  PCout, IRout, RFout, RZLOout, RZHIout, MDRout,
             PCin, IRin, RYin, RZin, MARin, MDRin, RFin, RHIin, RLOin,
             IncPC, Read, start, RFSelect, opSelect, instr_done, illegal, fault
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU instructions
// on the single-bus DataPath, with ALU start/finished handshake timeout.
module control_sequencer #(
   parameter logic [5:0]   INC_OP      = 6'd0,
   parameter logic [191:0] OP_MAP      = {6'd31, 6'd30, 6'd29, 6'd28, 6'd27, 6'd26, 6'd25, 6'd24,
                                          6'd23, 6'd22, 6'd21, 6'd20, 6'd19, 6'd18, 6'd17, 6'd16,
                                          6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10, 6'd9,  6'd8,
                                          6'd7,  6'd6,  6'd5,  6'd4,  6'd3,  6'd2,  6'd1,  6'd0},
   parameter int unsigned  ALU_TIMEOUT = 64
) (
   input  logic                Clock,
   input  logic                clear,
   control_sequencer_if.master bus
);

   localparam int unsigned CW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
   } state_t;

   state_t        state_q;
   logic          first_q;
   logic [CW-1:0] cnt_q;
   logic          fault_q;
   logic [4:0]    op_q;
   logic [3:0]    ra_q, rb_q, rc_q;

   function automatic logic is_alu3(input logic [4:0] op);
      return (op >= 5'd3) && (op <= 5'd10);
   endfunction

   function automatic logic is_hilo(input logic [4:0] op);
      return (op == 5'd15) || (op == 5'd16);
   endfunction

   function automatic logic is_unary(input logic [4:0] op);
      return (op == 5'd17) || (op == 5'd18);
   endfunction

   logic [4:0] ir_op;
   logic [3:0] ir_ra, ir_rb, ir_rc;
   logic       ir_legal;
   logic       unused_ir;

   assign ir_op     = bus.IR[31:27];
   assign ir_ra     = bus.IR[26:23];
   assign ir_rb     = bus.IR[22:19];
   assign ir_rc     = bus.IR[18:15];
   assign ir_legal  = is_alu3(ir_op) || is_hilo(ir_op) || is_unary(ir_op);
   assign unused_ir = ^bus.IR[14:0];

   logic [5:0] op_sel;
   logic [3:0] src_b;
   assign op_sel = OP_MAP[{3'b000, op_q} * 8'd6 +: 6];
   assign src_b  = is_unary(op_q) ? rb_q : rc_q;

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
      end else begin
         first_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.run && !fault_q) begin
                  state_q <= S_T0;
                  first_q <= 1'b1;
                  cnt_q   <= CNT_LOAD;
               end
            end
            S_T0: begin
               if (bus.finished) begin
                  state_q <= S_T1;
               end else if (cnt_q == '0) begin
                  fault_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_T1: state_q <= S_T2;
            S_T2: state_q <= S_T3;
            S_T3: begin
               // IR is only valid from T3 on; latch its fields so T4-T5 ignore later IR changes
               op_q <= ir_op;
               ra_q <= ir_ra;
               rb_q <= ir_rb;
               rc_q <= ir_rc;
               if (!ir_legal) begin
                  if (bus.run) begin
                     state_q <= S_T0;
                     first_q <= 1'b1;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  state_q <= S_T4;
                  first_q <= 1'b1;
                  cnt_q   <= CNT_LOAD;
               end
            end
            S_T4: begin
               if (bus.finished) begin
                  state_q <= S_T5;
               end else if (cnt_q == '0) begin
                  fault_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_T5, S_T6: begin
               if (state_q == S_T5 && is_hilo(op_q)) begin
                  state_q <= S_T6;
               end else if (bus.run) begin
                  state_q <= S_T0;
                  first_q <= 1'b1;
                  cnt_q   <= CNT_LOAD;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.PCout      = 1'b0;
      bus.IRout      = 1'b0;
      bus.RFout      = 1'b0;
      bus.RZLOout    = 1'b0;
      bus.RZHIout    = 1'b0;
      bus.MDRout     = 1'b0;
      bus.PCin       = 1'b0;
      bus.IRin       = 1'b0;
      bus.RYin       = 1'b0;
      bus.RZin       = 1'b0;
      bus.MARin      = 1'b0;
      bus.MDRin      = 1'b0;
      bus.RFin       = 1'b0;
      bus.RHIin      = 1'b0;
      bus.RLOin      = 1'b0;
      bus.IncPC      = 1'b0;
      bus.Read       = 1'b0;
      bus.start      = 1'b0;
      bus.RFSelect   = '0;
      bus.opSelect   = '0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
      bus.fault      = fault_q;
      case (state_q)
         S_T0: begin
            bus.PCout    = 1'b1;
            bus.MARin    = 1'b1;
            bus.IncPC    = 1'b1;
            bus.RZin     = 1'b1;
            bus.opSelect = INC_OP;
            bus.start    = first_q;
         end
         S_T1: begin
            bus.RZLOout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         S_T3: begin
            if (ir_legal) begin
               bus.RFout    = 1'b1;
               bus.RYin     = 1'b1;
               bus.RFSelect = {1'b0, ir_rb};
            end else begin
               bus.illegal = 1'b1;
            end
         end
         S_T4: begin
            bus.RFout    = 1'b1;
            bus.RZin     = 1'b1;
            bus.RFSelect = {1'b0, src_b};
            bus.opSelect = op_sel;
            bus.start    = first_q;
         end
         S_T5: begin
            bus.RZLOout  = 1'b1;
            bus.opSelect = op_sel;
            if (is_hilo(op_q)) begin
               bus.RLOin    = 1'b1;
               bus.RFSelect = {1'b0, src_b};
            end else begin
               bus.RFin       = 1'b1;
               bus.RFSelect   = {1'b0, ra_q};
               bus.instr_done = 1'b1;
            end
         end
         S_T6: begin
            bus.RZHIout    = 1'b1;
            bus.RHIin      = 1'b1;
            bus.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
